// File: rtl/pm_pkg.sv
// Shared power-management encodings and constants used by the power-request
// controller and its neighbours.
package pm_pkg;

  typedef enum logic [1:0] {
    PM_ON        = 2'b00,
    PM_ENTER_OFF = 2'b01,
    PM_OFF       = 2'b10,
    PM_ENTER_ON  = 2'b11
  } pm_state_e;

  // The sequencer needs three cycles to propagate a p_flag change.
  localparam int PM_MIN_SETTLE = 3;

  // Counter width able to hold the larger of the two terminal counts.
  function automatic int pm_cnt_width(input int idle_cycles, input int settle_cycles);
    int m;
    m = (idle_cycles > settle_cycles) ? idle_cycles : settle_cycles;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pm_request_ctrl.sv
// Power-request controller: times an idle window, drops p_flag to request
// power-down, raises it on wake, and holds each level for a settle window.
module pm_request_ctrl
  import pm_pkg::*;
#(
  parameter int IDLE_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       activity,
  input  logic       wake_req,
  input  logic       sleep_en,
  output logic       p_flag,
  output logic [1:0] pwr_state,
  output logic       sleep_ack,
  output logic       wake_ack
);

  localparam int CW = pm_cnt_width(IDLE_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < PM_MIN_SETTLE) begin : g_bad_settle
      $error("pm_request_ctrl: SETTLE_CYCLES below sequencer minimum");
    end
    if (IDLE_CYCLES < 1) begin : g_bad_idle
      $error("pm_request_ctrl: IDLE_CYCLES must be at least 1");
    end
  endgenerate

  pm_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p_flag_q, p_flag_d;
  logic          sleep_ack_q, sleep_ack_d;
  logic          wake_ack_q, wake_ack_d;
  logic          wake_pend_q, wake_pend_d;

  logic idle;
  logic wake_cause;

  assign idle       = sleep_en & ~activity & ~wake_req;
  assign wake_cause = ~idle;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_flag_d    = p_flag_q;
    sleep_ack_d = 1'b0;
    wake_ack_d  = 1'b0;
    wake_pend_d = wake_pend_q;

    case (state_q)
      PM_ON: begin
        // Any non-idle sample, including one on the terminal count, restarts.
        if (!idle) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d  = PM_ENTER_OFF;
          p_flag_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PM_ENTER_OFF: begin
        // Power-down is never aborted; a wake cause is remembered instead.
        if (wake_cause) wake_pend_d = 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          state_d     = PM_OFF;
          cnt_d       = '0;
          sleep_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PM_OFF: begin
        if (wake_pend_q || wake_cause) begin
          state_d     = PM_ENTER_ON;
          p_flag_d    = 1'b1;
          cnt_d       = '0;
          wake_pend_d = 1'b0;
        end
      end

      PM_ENTER_ON: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d    = PM_ON;
          cnt_d      = '0;
          wake_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d  = PM_ON;
        cnt_d    = '0;
        p_flag_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= PM_ON;
      cnt_q       <= '0;
      p_flag_q    <= 1'b1;
      sleep_ack_q <= 1'b0;
      wake_ack_q  <= 1'b0;
      wake_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p_flag_q    <= p_flag_d;
      sleep_ack_q <= sleep_ack_d;
      wake_ack_q  <= wake_ack_d;
      wake_pend_q <= wake_pend_d;
    end
  end

  assign p_flag    = p_flag_q;
  assign pwr_state = state_q;
  assign sleep_ack = sleep_ack_q;
  assign wake_ack  = wake_ack_q;

  a_acks_exclusive: assert property (@(posedge CLK) disable iff (!RST_N)
    !(sleep_ack_q && wake_ack_q));

  a_acks_single: assert property (@(posedge CLK) disable iff (!RST_N)
    (sleep_ack_q || wake_ack_q) |=> !(sleep_ack_q || wake_ack_q));

  // p_flag is low exactly while heading into or sitting in OFF.
  a_flag_matches_state: assert property (@(posedge CLK) disable iff (!RST_N)
    p_flag_q == ((state_q == PM_ON) || (state_q == PM_ENTER_ON)));

endmodule

// File: tb/tb_pm_request_ctrl.sv
// Self-checking bench for pm_request_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_pm_request_ctrl;

  localparam int IDLE   = 8;
  localparam int SETTLE = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       activity = 1'b1;
  logic       wake_req = 1'b0;
  logic       sleep_en = 1'b1;
  logic       p_flag;
  logic [1:0] pwr_state;
  logic       sleep_ack;
  logic       wake_ack;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  pm_request_ctrl #(.IDLE_CYCLES(IDLE), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .activity (activity),
    .wake_req (wake_req),
    .sleep_en (sleep_en),
    .p_flag   (p_flag),
    .pwr_state(pwr_state),
    .sleep_ack(sleep_ack),
    .wake_ack (wake_ack)
  );

  // Behavioural model: phase plus idle streak length and remaining dwell.
  int m_phase;    // 0 ON, 1 ENTER_OFF, 2 OFF, 3 ENTER_ON
  int m_streak;
  int m_left;
  bit m_pend;
  bit m_sack;
  bit m_wack;
  bit prev_ack;

  function void model_reset();
    m_phase = 0; m_streak = 0; m_left = 0;
    m_pend = 0;  m_sack = 0;   m_wack = 0;
  endfunction

  function void model_step(input bit act, input bit wr, input bit se);
    bit idle;
    idle = se && !act && !wr;
    m_sack = 0;
    m_wack = 0;
    case (m_phase)
      0: begin
        m_streak = idle ? m_streak + 1 : 0;
        if (m_streak == IDLE) begin
          m_phase = 1; m_left = SETTLE; m_streak = 0;
        end
      end
      1: begin
        if (!idle) m_pend = 1;
        m_left = m_left - 1;
        if (m_left == 0) begin m_phase = 2; m_sack = 1; end
      end
      2: begin
        if (m_pend || !idle) begin m_phase = 3; m_left = SETTLE; m_pend = 0; end
      end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_phase = 0; m_wack = 1; m_streak = 0; end
      end
    endcase
  endfunction

  function void chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else model_step(activity, wake_req, sleep_en);
    #1;
    chk("model_p_flag", 8'(p_flag), 8'((m_phase == 0) || (m_phase == 3)));
    chk("model_pwr_state", 8'(pwr_state), 8'(m_phase));
    chk("model_sleep_ack", 8'(sleep_ack), 8'(m_sack));
    chk("model_wake_ack", 8'(wake_ack), 8'(m_wack));
  endtask

  typedef struct {
    bit       act;
    bit       wr;
    bit       se;
    bit       pf;
    bit [1:0] st;
    bit       sa;
    bit       wa;
  } vec_t;

  vec_t tbl[$];

  function void add_vec(input bit act, input bit wr, input bit se,
                        input bit pf, input bit [1:0] st, input bit sa, input bit wa);
    vec_t v;
    v.act = act; v.wr = wr; v.se = se; v.pf = pf; v.st = st; v.sa = sa; v.wa = wa;
    tbl.push_back(v);
  endfunction

  // Ticks with idle inputs until p_flag falls; returns edges taken, -1 on timeout.
  task automatic count_to_fall(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (p_flag === 1'b0) begin n = i; break; end
    end
  endtask

  initial begin
    int n;

    // Idle-to-sleep, wake during second ENTER_OFF cycle, auto wake-up.
    add_vec(1, 0, 1, 1, 2'd0, 0, 0);
    for (int i = 0; i < 7; i++) add_vec(0, 0, 1, 1, 2'd0, 0, 0);
    add_vec(0, 0, 1, 0, 2'd1, 0, 0);
    add_vec(0, 0, 1, 0, 2'd1, 0, 0);
    add_vec(0, 1, 1, 0, 2'd1, 0, 0);
    add_vec(0, 0, 1, 0, 2'd1, 0, 0);
    add_vec(0, 0, 1, 0, 2'd2, 1, 0);
    add_vec(0, 0, 1, 1, 2'd3, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 1, 1, 2'd3, 0, 0);
    add_vec(1, 0, 1, 1, 2'd0, 0, 1);
    add_vec(1, 0, 1, 1, 2'd0, 0, 0);

    model_reset();
    prev_ack = 0;

    // Reset, then activity held for 20 cycles.
    repeat (3) tick();
    chk("reset_p_flag", 8'(p_flag), 8'd1);
    chk("reset_pwr_state", 8'(pwr_state), 8'd0);
    #2 RST_N = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (p_flag !== 1'b1 || pwr_state !== 2'd0 || sleep_ack || wake_ack) n++;
    end
    chk("busy_hold_violations", 8'(n), 8'd0);

    // Directed table.
    foreach (tbl[i]) begin
      activity = tbl[i].act; wake_req = tbl[i].wr; sleep_en = tbl[i].se;
      tick();
      chk($sformatf("vec%0d_p_flag", i), 8'(p_flag), 8'(tbl[i].pf));
      chk($sformatf("vec%0d_pwr_state", i), 8'(pwr_state), 8'(tbl[i].st));
      chk($sformatf("vec%0d_sleep_ack", i), 8'(sleep_ack), 8'(tbl[i].sa));
      chk($sformatf("vec%0d_wake_ack", i), 8'(wake_ack), 8'(tbl[i].wa));
    end

    // Activity pulse on the 8th sample restarts the idle window.
    activity = 1'b0; wake_req = 1'b0; sleep_en = 1'b1;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      activity = (i == 8);
      tick();
      if (p_flag === 1'b0) begin n = i; break; end
    end
    activity = 1'b0;
    chk("restart_fall_edge", 8'(n), 8'd16);

    // Steady OFF, then a single-cycle wake_req pulse.
    repeat (4) tick();
    chk("off_sleep_ack", 8'(sleep_ack), 8'd1);
    repeat (3) tick();
    chk("steady_off_state", 8'(pwr_state), 8'd2);
    chk("steady_off_p_flag", 8'(p_flag), 8'd0);
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    chk("wake_p_flag", 8'(p_flag), 8'd1);
    chk("wake_state", 8'(pwr_state), 8'd3);
    repeat (3) tick();
    chk("enter_on_hold", 8'(pwr_state), 8'd3);
    tick();
    chk("wake_ack_pulse", 8'(wake_ack), 8'd1);
    chk("back_on_state", 8'(pwr_state), 8'd0);

    // Asynchronous reset in the middle of ENTER_OFF.
    activity = 1'b1; tick();
    activity = 1'b0;
    count_to_fall(n);
    chk("pre_reset_fall_edge", 8'(n), 8'd8);
    tick();
    chk("pre_reset_state", 8'(pwr_state), 8'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("async_reset_p_flag", 8'(p_flag), 8'd1);
    chk("async_reset_state", 8'(pwr_state), 8'd0);
    model_reset();
    repeat (2) tick();
    RST_N = 1'b1;
    count_to_fall(n);
    chk("post_reset_fall_edge", 8'(n), 8'd8);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      activity = ($urandom_range(0, 9) == 0);
      wake_req = ($urandom_range(0, 29) == 0);
      sleep_en = ($urandom_range(0, 19) != 0);
      tick();
      chk("ack_spacing", 8'((sleep_ack || wake_ack) && prev_ack), 8'd0);
      prev_ack = sleep_ack || wake_ack;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
